// File: rtl/hazard_pkg.sv
// Shared defaults for the hazard controller and its busy timer.
package hazard_pkg;
    localparam int REG_AW_DEF   = 5;   // register-address width
    localparam int TW_DEF       = 2;   // Tuse/Tnew field width
    localparam int MULT_CYC_DEF = 5;   // mult/multu busy cycles after issue
    localparam int DIV_CYC_DEF  = 10;  // div/divu busy cycles after issue
    localparam int ZERO_REG     = 0;   // $zero: writes to it never create a hazard
endpackage

// File: rtl/md_busy_timer.sv
// HI/LO unit busy timer: loads the op latency on every start, counts down to 0.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] cnt;

    // Reload on any start (a new op restarts the count), else count down and hold at 0.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    // Busy covers the issue cycle itself; forced low while reset is held.
    assign busy = ~reset & (start | (cnt != '0));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew data-hazard stall plus HI/LO busy stall.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int TW       = TW_DEF,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] a1_d,
    input  logic [REG_AW-1:0] a2_d,
    input  logic              use_rs_d,
    input  logic              use_rt_d,
    input  logic [TW-1:0]     tuse_rs_d,
    input  logic [TW-1:0]     tuse_rt_d,
    input  logic [REG_AW-1:0] a3_e,
    input  logic [REG_AW-1:0] a3_m,
    input  logic              we_e,
    input  logic              we_m,
    input  logic [TW-1:0]     tnew_e,
    input  logic [TW-1:0]     tnew_m,
    input  logic              md_start_e,
    input  logic              md_is_div_e,
    input  logic              md_use_d,
    output logic              stall,
    output logic              en_pc,
    output logic              en_d,
    output logic              flush_e,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);
    // Index 0 = rs / E stage, index 1 = rt / M stage.
    logic [1:0][REG_AW-1:0] src_a;
    logic [1:0]             src_use;
    logic [1:0][TW-1:0]     src_tuse;
    logic [1:0][REG_AW-1:0] dst_a;
    logic [1:0]             dst_we;
    logic [1:0][TW-1:0]     dst_tnew;
    logic [1:0][1:0]        haz;
    logic                   data_haz;
    logic                   md_haz;

    assign src_a    = {a2_d, a1_d};
    assign src_use  = {use_rt_d, use_rs_d};
    assign src_tuse = {tuse_rt_d, tuse_rs_d};
    assign dst_a    = {a3_m, a3_e};
    assign dst_we   = {we_m, we_e};
    assign dst_tnew = {tnew_m, tnew_e};

    // A producer still needing more cycles than the consumer can wait forces a stall.
    for (genvar s = 0; s < 2; s++) begin : g_src
        for (genvar x = 0; x < 2; x++) begin : g_stage
            assign haz[s][x] = src_use[s] & dst_we[x]
                             & (dst_a[x] != REG_AW'(ZERO_REG))
                             & (dst_a[x] == src_a[s])
                             & (dst_tnew[x] > src_tuse[s]);
        end
    end

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_e),
        .is_div (md_is_div_e),
        .busy   (md_busy)
    );

    assign data_haz = |haz;
    assign md_haz   = md_use_d & md_busy;
    assign stall    = ~reset & (data_haz | md_haz);
    assign en_pc    = ~stall;
    assign en_d     = ~stall;
    assign flush_e  = stall;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model.
module tb_hazard_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int CNT_MAX = 15;  // bench uses CNT_W = 4

    logic       clk, reset;
    logic [4:0] a1_d, a2_d, a3_e, a3_m;
    logic       use_rs_d, use_rt_d, we_e, we_m;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
    logic       md_start_e, md_is_div_e, md_use_d;
    logic       stall, en_pc, en_d, flush_e, md_busy;
    logic [3:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .a1_d(a1_d), .a2_d(a2_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .a3_e(a3_e), .a3_m(a3_m), .we_e(we_e), .we_m(we_m),
        .tnew_e(tnew_e), .tnew_m(tnew_m),
        .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .md_use_d(md_use_d),
        .stall(stall), .en_pc(en_pc), .en_d(en_d), .flush_e(flush_e),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int cyc      = 0;   // index of the current cycle
    int busy_end = -1;  // last cycle the HI/LO unit is busy
    int m_cnt    = 0;

    function automatic bit m_data_haz();
        for (int s = 0; s < 2; s++) begin
            int sa = s ? a2_d : a1_d;
            bit su = s ? use_rt_d : use_rs_d;
            int st = s ? tuse_rt_d : tuse_rs_d;
            for (int x = 0; x < 2; x++) begin
                int da = x ? a3_m : a3_e;
                bit dw = x ? we_m : we_e;
                int dt = x ? tnew_m : tnew_e;
                if (su && dw && da != 0 && da == sa && dt > st) return 1;
            end
        end
        return 0;
    endfunction

    function automatic bit m_busy();
        return !reset && (md_start_e || cyc <= busy_end);
    endfunction

    function automatic bit m_stall();
        return !reset && (m_data_haz() || (md_use_d && m_busy()));
    endfunction

    always @(posedge clk) begin
        bit s;
        s = m_stall();
        if (reset) begin
            busy_end = -1;
            m_cnt    = 0;
        end else begin
            if (md_start_e) busy_end = cyc + (md_is_div_e ? DIV_N : MULT_N);
            if (s && m_cnt < CNT_MAX) m_cnt++;
        end
        cyc++;
    end

    // Every-cycle comparison once the first edge has defined the registers.
    always @(negedge clk) begin
        if (cyc > 0) begin
            bit es;
            es = m_stall();
            chk("m_stall",   stall,     es);
            chk("m_en_pc",   en_pc,     !es);
            chk("m_en_d",    en_d,      !es);
            chk("m_flush_e", flush_e,   es);
            chk("m_md_busy", md_busy,   m_busy());
            chk("m_cnt",     stall_cnt, m_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic go();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    task automatic clr();
        a1_d = 0; a2_d = 0; a3_e = 0; a3_m = 0;
        use_rs_d = 0; use_rt_d = 0; we_e = 0; we_m = 0;
        tuse_rs_d = 0; tuse_rt_d = 0; tnew_e = 0; tnew_m = 0;
        md_start_e = 0; md_is_div_e = 0; md_use_d = 0;
    endtask

    task automatic rs_e_haz();
        clr();
        a3_e = 2; we_e = 1; tnew_e = 2; a1_d = 2; use_rs_d = 1; tuse_rs_d = 0;
    endtask

    initial begin
        reset = 1;
        rs_e_haz();
        md_start_e = 1; md_is_div_e = 1; md_use_d = 1;
        look();
        chk("rst_stall", stall, 0);
        chk("rst_en_pc", en_pc, 1);
        chk("rst_en_d", en_d, 1);
        chk("rst_flush", flush_e, 0);
        chk("rst_busy", md_busy, 0);
        go(); go();
        reset = 0; clr();
        look();
        chk("post_rst_cnt", stall_cnt, 0);
        chk("post_rst_busy", md_busy, 0);

        // rs vs E-stage producer
        go(); rs_e_haz(); look();
        chk("rs_e_t0_stall", stall, 1);
        chk("rs_e_t0_flush", flush_e, 1);
        chk("rs_e_t0_en_pc", en_pc, 0);
        go(); tuse_rs_d = 1; look();
        chk("rs_e_t1_stall", stall, 1);
        go(); tnew_e = 1; look();
        chk("rs_e_ready", stall, 0);

        // $zero and non-writing producers
        go(); clr(); a3_e = 0; we_e = 1; tnew_e = 2; a1_d = 0; use_rs_d = 1; look();
        chk("zero_reg", stall, 0);
        go(); we_e = 0; a3_e = 5; a1_d = 5; look();
        chk("no_we", stall, 0);

        // rt vs M-stage producer
        go(); clr(); a3_m = 7; tnew_m = 1; we_m = 1; a2_d = 7; use_rt_d = 1; look();
        chk("rt_m_stall", stall, 1);
        go(); tuse_rt_d = 1; look();
        chk("rt_m_ready", stall, 0);

        // rt vs E-stage with Tuse 2
        go(); clr(); a3_e = 3; we_e = 1; tnew_e = 3; a2_d = 3; use_rt_d = 1; tuse_rt_d = 2; look();
        chk("rt_e_tuse2", stall, 1);
        go(); use_rt_d = 0; look();
        chk("rt_unused", stall, 0);

        // divide: stall cycles 0..10
        go(); clr(); md_use_d = 1; md_start_e = 1; md_is_div_e = 1; look();
        chk("div_c0", stall, 1);
        for (int c = 1; c <= 12; c++) begin
            go(); md_start_e = 0; md_is_div_e = 0; look();
            chk($sformatf("div_c%0d", c), stall, (c <= 10));
        end

        // multiply: stall cycles 0..5
        go(); md_start_e = 1; md_is_div_e = 0; look();
        chk("mul_c0", stall, 1);
        for (int c = 1; c <= 7; c++) begin
            go(); md_start_e = 0; look();
            chk($sformatf("mul_c%0d", c), stall, (c <= 5));
        end

        // mult issued at cycle 3 of a divide reloads: busy through cycle 8
        go(); clr(); md_start_e = 1; md_is_div_e = 1; look();
        chk("reload_c0", md_busy, 1);
        go(); md_start_e = 0; look();
        go(); look();
        go(); md_start_e = 1; md_is_div_e = 0; look();
        for (int c = 4; c <= 10; c++) begin
            go(); md_start_e = 0; md_is_div_e = 0; look();
            chk($sformatf("reload_c%0d", c), md_busy, (c <= 8));
        end

        // reset in the middle of a divide
        go(); clr(); md_start_e = 1; md_is_div_e = 1; look();
        for (int c = 1; c <= 3; c++) begin
            go(); md_start_e = 0; look();
            chk($sformatf("divrst_c%0d", c), md_busy, 1);
        end
        go(); reset = 1; look();
        chk("divrst_c4_busy", md_busy, 0);
        go(); reset = 0; look();
        chk("divrst_c5_busy", md_busy, 0);
        chk("divrst_c5_cnt", stall_cnt, 0);
        go(); look();
        chk("divrst_c6_busy", md_busy, 0);

        // saturation of the 4-bit stall counter
        for (int k = 1; k <= 20; k++) begin
            go(); rs_e_haz(); look();
            chk($sformatf("sat_k%0d", k), stall_cnt, (k - 1 < CNT_MAX) ? k - 1 : CNT_MAX);
        end
        for (int k = 0; k < 3; k++) begin
            go(); look();
            chk("sat_hold", stall_cnt, CNT_MAX);
        end
        go(); clr(); look();
        chk("sat_final", stall_cnt, CNT_MAX);

        go();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
